// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, parity mode encoding and bit helpers.
package uart_pkg;

  typedef logic [2:0] uart_rx_state_t;

  localparam uart_rx_state_t ST_IDLE   = 3'd0;
  localparam uart_rx_state_t ST_START  = 3'd1;
  localparam uart_rx_state_t ST_DATA   = 3'd2;
  localparam uart_rx_state_t ST_PARITY = 3'd3;
  localparam uart_rx_state_t ST_STOP1  = 3'd4;
  localparam uart_rx_state_t ST_STOP2  = 3'd5;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_t;

  localparam int unsigned MIN_BIT_PERIOD = 7;

  function automatic logic parity_enabled(input parity_mode_t mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic majority3(input logic [2:0] taps);
    return (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received words; pointers carry an extra wrap bit for full/empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver with run-time parity/stop config, majority sampling, break detection and receive buffer.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_cfg_i,
  input  logic [15:0]                       bit_period_i,
  input  logic [1:0]                        parity_mode_i,
  input  logic                              stop_bits_i,
  input  logic                              uart_rxd,
  input  logic                              rx_en_i,
  input  logic                              rx_ready_i,
  output logic                              rx_valid_o,
  output logic [DATA_BITS-1:0]              rx_data_o,
  output logic                              rx_parity_err_o,
  output logic                              rx_frame_err_o,
  output logic                              rx_break_o,
  output logic                              rx_overrun_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level_o
);

  localparam int unsigned WORD_W = DATA_BITS + 3;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH+1);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam logic [15:0] RESET_PERIOD = 16'(CLK_FREQ / BAUD_RATE - 1);

  // Input synchronizer and 3-tap majority filter; idle line level is 1.
  logic       sync1;
  logic       line_sync;
  logic [2:0] taps;
  logic       bit_sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      line_sync <= 1'b1;
      taps      <= 3'b111;
    end else begin
      sync1     <= uart_rxd;
      line_sync <= sync1;
      taps      <= {taps[1:0], line_sync};
    end
  end

  assign bit_sample = majority3(taps);

  logic [15:0]  cfg_period;
  parity_mode_t cfg_parity;
  logic         cfg_two_stop;

  // Periods below the minimum are clamped so the half-bit start check stays meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_period   <= RESET_PERIOD;
      cfg_parity   <= PAR_NONE;
      cfg_two_stop <= 1'b0;
    end else if (wr_cfg_i) begin
      cfg_period   <= (bit_period_i < 16'(MIN_BIT_PERIOD)) ? 16'(MIN_BIT_PERIOD) : bit_period_i;
      cfg_parity   <= parity_mode_t'(parity_mode_i);
      cfg_two_stop <= stop_bits_i;
    end
  end

  uart_rx_state_t       state;
  uart_rx_state_t       state_n;
  logic [15:0]          cnt;
  logic [15:0]          cnt_n;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_n;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_n;
  logic                 perr;
  logic                 perr_n;
  logic                 ferr;
  logic                 ferr_n;
  logic                 all_low;
  logic                 all_low_n;
  logic                 armed;
  logic                 armed_n;
  logic                 push;
  logic [WORD_W-1:0]    push_word;
  logic                 exp_parity;

  assign exp_parity = (cfg_parity == PAR_ODD) ? ~(^shreg) : (^shreg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      all_low <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
      all_low <= all_low_n;
      armed   <= armed_n;
    end
  end

  // Frame FSM: every non-IDLE state counts down and acts on the sample taken at zero.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    perr_n    = perr;
    ferr_n    = ferr;
    all_low_n = all_low;
    armed_n   = armed;
    push      = 1'b0;
    push_word = '0;

    if (wr_cfg_i || !rx_en_i) begin
      state_n = ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (line_sync) begin
        armed_n = 1'b1;
      end else if (armed) begin
        state_n = ST_START;
        cnt_n   = {1'b0, cfg_period[15:1]};
      end
    end else if (cnt != 16'd0) begin
      cnt_n = cnt - 16'd1;
    end else begin
      cnt_n = cfg_period;
      case (state)
        ST_START: begin
          if (bit_sample) begin
            state_n = ST_IDLE;
          end else begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
            perr_n    = 1'b0;
            ferr_n    = 1'b0;
            all_low_n = 1'b1;
          end
        end
        ST_DATA: begin
          shreg_n   = {bit_sample, shreg[DATA_BITS-1:1]};
          all_low_n = all_low & ~bit_sample;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            state_n = parity_enabled(cfg_parity) ? ST_PARITY : ST_STOP1;
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end
        ST_PARITY: begin
          perr_n    = (bit_sample != exp_parity);
          all_low_n = all_low & ~bit_sample;
          state_n   = ST_STOP1;
        end
        ST_STOP1: begin
          ferr_n    = ferr | ~bit_sample;
          all_low_n = all_low & ~bit_sample;
          if (cfg_two_stop) begin
            state_n = ST_STOP2;
          end else begin
            push    = 1'b1;
            state_n = ST_IDLE;
          end
        end
        ST_STOP2: begin
          ferr_n    = ferr | ~bit_sample;
          all_low_n = all_low & ~bit_sample;
          push      = 1'b1;
          state_n   = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end

    // A frame error leaves the line possibly stuck low; wait for a high level before re-arming.
    if (push && ferr_n) begin
      armed_n = 1'b0;
    end
    if (push) begin
      push_word = {all_low_n, ferr_n, perr_n, shreg_n};
    end
  end

  logic              buf_full;
  logic              buf_empty;
  logic              pop;
  logic [WORD_W-1:0] buf_rdata;
  logic [LVL_W-1:0]  buf_level;

  assign pop = rx_ready_i && !buf_empty;

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_word),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .level (buf_level)
  );
`else
  logic              hold_valid;
  logic [WORD_W-1:0] hold_word;

  // Single holding register; a push over an occupied register needs a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_word  <= '0;
    end else if (push && (!hold_valid || pop)) begin
      hold_valid <= 1'b1;
      hold_word  <= push_word;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_full  = hold_valid;
  assign buf_empty = !hold_valid;
  assign buf_rdata = hold_valid ? hold_word : '0;
  assign buf_level = LVL_W'(hold_valid);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overrun_o <= 1'b0;
    end else begin
      rx_overrun_o <= push && buf_full && !pop;
    end
  end

  assign rx_valid_o = !buf_empty;
  assign {rx_break_o, rx_frame_err_o, rx_parity_err_o, rx_data_o} = buf_rdata;
  assign rx_level_o = buf_level;

endmodule
